// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_ctrl_pkg;
   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {BOOT, RUN, DRAIN} fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            filled;
   } fq_entry_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: EX redirect, instruction-memory channel and IF/ID handoff.
interface fetch_ctrl_if;
   import fetch_ctrl_pkg::*;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_pc_plus_4;
   logic [31:0]     id_instr;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
      output imem_req_valid, imem_req_addr, id_valid, id_pc, id_pc_plus_4, id_instr
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
      input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_pc_plus_4, id_instr
   );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue: entries are allocated at request, filled in order at
// response and popped at the head toward decode.
module fetch_queue
   import fetch_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   alloc_en,
   input  logic [XLEN-1:0]        alloc_pc,
   input  logic                   fill_en,
   input  logic [31:0]            fill_instr,
   input  logic                   pop_en,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [$clog2(DEPTH):0] unfilled,
   output fq_entry_t              head
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fq_entry_t        ent [DEPTH];
   logic [PTR_W-1:0] head_ptr, tail_ptr, fill_ptr;

   assign head = ent[head_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            ent[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
         head_ptr  <= '0;
         tail_ptr  <= '0;
         fill_ptr  <= '0;
         occupancy <= '0;
         unfilled  <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++)
            ent[i].filled <= 1'b0;
         head_ptr  <= '0;
         tail_ptr  <= '0;
         fill_ptr  <= '0;
         occupancy <= '0;
         unfilled  <= '0;
      end else begin
         if (alloc_en) begin
            ent[tail_ptr].pc     <= alloc_pc;
            ent[tail_ptr].filled <= 1'b0;
            tail_ptr             <= tail_ptr + 1'b1;
         end
         if (fill_en) begin
            ent[fill_ptr].instr  <= fill_instr;
            ent[fill_ptr].filled <= 1'b1;
            fill_ptr             <= fill_ptr + 1'b1;
         end
         if (pop_en) begin
            ent[head_ptr].filled <= 1'b0;
            head_ptr             <= head_ptr + 1'b1;
         end
         occupancy <= occupancy + CNT_W'(alloc_en) - CNT_W'(pop_en);
         unfilled  <= unfilled + CNT_W'(alloc_en) - CNT_W'(fill_en);
      end
   end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues in-order imem requests and
// discards responses made stale by an EX redirect.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter int              FQ_DEPTH     = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_ctrl_if.master bus
);
   localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

   fetch_state_e     state;
   logic [XLEN-1:0]  fetch_pc;
   logic [CNT_W-1:0] drop_cnt, occupancy, unfilled, drop_next, drain_left;
   fq_entry_t        head;
   logic             req_fire, pop_fire, fill_en;

   assign bus.imem_req_valid = (state == RUN) && (occupancy < CNT_W'(FQ_DEPTH)) && !bus.redirect_valid;
   assign bus.imem_req_addr  = fetch_pc;
   assign bus.id_valid       = head.filled && !bus.redirect_valid;
   assign bus.id_pc          = head.pc;
   assign bus.id_pc_plus_4   = head.pc + XLEN'(4);
   assign bus.id_instr       = head.instr;

   assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
   assign pop_fire = bus.id_valid && bus.id_ready;
   assign fill_en  = bus.imem_rsp_valid && (state == RUN) && !bus.redirect_valid;

   // A response landing in the redirect cycle is itself one of the stale ones.
   assign drop_next  = drop_cnt + unfilled - CNT_W'(bus.imem_rsp_valid);
   assign drain_left = drop_cnt - CNT_W'(bus.imem_rsp_valid);

   fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.redirect_valid),
      .alloc_en   (req_fire),
      .alloc_pc   (fetch_pc),
      .fill_en    (fill_en),
      .fill_instr (bus.imem_rsp_data),
      .pop_en     (pop_fire),
      .occupancy  (occupancy),
      .unfilled   (unfilled),
      .head       (head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= BOOT;
         fetch_pc <= RESET_VECTOR;
         drop_cnt <= '0;
      end else if (bus.redirect_valid) begin
         fetch_pc <= bus.redirect_pc;
         if (state == BOOT) begin
            state    <= RUN;
            drop_cnt <= '0;
         end else begin
            drop_cnt <= drop_next;
            state    <= (drop_next != '0) ? DRAIN : RUN;
         end
      end else begin
         case (state)
            BOOT:  state <= RUN;
            RUN:   if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            DRAIN: begin
               drop_cnt <= drain_left;
               if (drain_left == '0) state <= RUN;
            end
            default: state <= BOOT;
         endcase
      end
   end

   // Every response must belong to either a live or a stale request.
   assert property (@(posedge clk) disable iff (rst)
      bus.imem_rsp_valid |-> (unfilled != '0 || drop_cnt != '0));
endmodule
